// File: rtl/cbl_pkg.sv
// Shared definitions for the Core-B Lite slave-side decode/mux slice:
// bus widths, transfer-mode encodings and small sizing helpers.
package cbl_pkg;

  localparam int CBL_AW = 32;
  localparam int CBL_DW = 39;

  localparam logic [2:0] MOD_IDLE    = 3'b000;
  localparam logic [2:0] MOD_BUSY    = 3'b001;
  localparam logic [2:0] MOD_LDADDR  = 3'b010;
  localparam logic [2:0] MOD_SEQADDR = 3'b011;

  // Width of a slave index able to hold 0..nslv, where nslv names the
  // implicit default slave.
  function automatic int dselWidth(input int nslv);
    int w;
    w = $clog2(nslv + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Only load/sequential address modes are real transfers; IDLE, BUSY and
  // the reserved 1xx encodings never qualify for error capture.
  function automatic logic isTransfer(input logic [2:0] mode);
    return (mode == MOD_LDADDR) || (mode == MOD_SEQADDR);
  endfunction

endpackage

// File: rtl/cbl_slv_dec_mux_if.sv
// Bus bundle between the master-side fabric, the mapped slaves, the default
// slave and the decode/mux block. The "slave" modport is the decoder's view;
// the "master" modport is the view of everything around it.
interface cbl_slv_dec_mux_if
  import cbl_pkg::*;
#(
  parameter int NSLV = 2
);

  logic [CBL_AW-1:0]      MmADDR;
  logic [2:0]             MmMOD;
  logic [NSLV-1:0]        SxSEL;
  logic                   DxSEL;
  logic [CBL_DW*NSLV-1:0] SxRDT_VEC;
  logic [NSLV-1:0]        SxRDY_VEC;
  logic [NSLV-1:0]        SxERR_VEC;
  logic [CBL_DW-1:0]      DRDT;
  logic                   DRDY;
  logic                   DERR;
  logic [CBL_DW-1:0]      MsRDT;
  logic                   MsRDY;
  logic                   MsERR;
  logic                   ERR_CLR;
  logic                   ERR_VLD;
  logic [CBL_AW-1:0]      ERR_ADDR;

  modport slave (
    input  MmADDR, MmMOD,
    input  SxRDT_VEC, SxRDY_VEC, SxERR_VEC,
    input  DRDT, DRDY, DERR,
    input  ERR_CLR,
    output SxSEL, DxSEL,
    output MsRDT, MsRDY, MsERR,
    output ERR_VLD, ERR_ADDR
  );

  modport master (
    output MmADDR, MmMOD,
    output SxRDT_VEC, SxRDY_VEC, SxERR_VEC,
    output DRDT, DRDY, DERR,
    output ERR_CLR,
    input  SxSEL, DxSEL,
    input  MsRDT, MsRDY, MsERR,
    input  ERR_VLD, ERR_ADDR
  );

endinterface

// File: rtl/cbl_addr_dec.sv
// Combinational priority region decoder. Each mapped slave owns the region
// where (addr & mask) == base; the lowest index wins on overlap and the
// default slave takes everything that hits no region.
module cbl_addr_dec
  import cbl_pkg::*;
#(
  parameter int                   NSLV     = 2,
  parameter logic [NSLV*32-1:0]   BASE_VEC = {32'h4000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0]   MASK_VEC = {32'hF000_0000, 32'hF000_0000},
  parameter int                   DSW      = dselWidth(NSLV)
) (
  input  logic [CBL_AW-1:0] addr_i,
  output logic [NSLV-1:0]   sel_o,
  output logic              dflt_o,
  output logic [DSW-1:0]    idx_o
);

  logic [NSLV-1:0] hit;
  logic            found;

  // Raw region compare for every mapped slave.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit[i] = ((addr_i & MASK_VEC[i*32 +: 32]) == BASE_VEC[i*32 +: 32]);
    end
  end

  // Priority pick: first hit from index 0 upward, else the default index.
  always_comb begin
    sel_o = '0;
    idx_o = DSW'(NSLV);
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit[i] && !found) begin
        sel_o[i] = 1'b1;
        idx_o    = DSW'(i);
        found    = 1'b1;
      end
    end
  end

  assign dflt_o = ~|hit;

endmodule

// File: rtl/cbl_slv_dec_mux.sv
// Core-B Lite address decoder and slave response multiplexer. Drives the
// address-phase selects, registers the winning slave for the data phase,
// steers that slave's response back to the master and latches the address
// of the first errored real transfer.
module cbl_slv_dec_mux
  import cbl_pkg::*;
#(
  parameter int                 NSLV     = 2,
  parameter logic [NSLV*32-1:0] BASE_VEC = {32'h4000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] MASK_VEC = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                CLK,
  input  logic                nRST,
  cbl_slv_dec_mux_if.slave    bus
);

  localparam int             DSW      = dselWidth(NSLV);
  localparam logic [DSW-1:0] DSEL_DEF = DSW'(NSLV);

  logic [NSLV-1:0]   decSel;
  logic              decDflt;
  logic [DSW-1:0]    decIdx;

  logic [DSW-1:0]    dsel_q, dsel_d;
  logic [CBL_AW-1:0] addr_q, addr_d;
  logic              act_q, act_d;
  logic              errVld_q, errVld_d;
  logic [CBL_AW-1:0] errAddr_q, errAddr_d;

  logic [CBL_DW-1:0] msRdt;
  logic              msRdy;
  logic              msErr;
  logic              capture;

  cbl_addr_dec #(
    .NSLV     (NSLV),
    .BASE_VEC (BASE_VEC),
    .MASK_VEC (MASK_VEC),
    .DSW      (DSW)
  ) u_dec (
    .addr_i (bus.MmADDR),
    .sel_o  (decSel),
    .dflt_o (decDflt),
    .idx_o  (decIdx)
  );

  assign bus.SxSEL = decSel;
  assign bus.DxSEL = decDflt;

  // Data-phase response steering from the registered slave index.
  always_comb begin
    msRdt = bus.DRDT;
    msRdy = bus.DRDY;
    msErr = bus.DERR;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q == DSW'(i)) begin
        msRdt = bus.SxRDT_VEC[i*CBL_DW +: CBL_DW];
        msRdy = bus.SxRDY_VEC[i];
        msErr = bus.SxERR_VEC[i];
      end
    end
  end

  assign bus.MsRDT = msRdt;
  assign bus.MsRDY = msRdy;
  assign bus.MsERR = msErr;

  // Address phase advances into the data phase only when the bus is ready;
  // wait states freeze the current data-phase owner.
  always_comb begin
    dsel_d = dsel_q;
    addr_d = addr_q;
    act_d  = act_q;
    if (msRdy) begin
      dsel_d = decIdx;
      addr_d = bus.MmADDR;
      act_d  = isTransfer(bus.MmMOD);
    end
  end

  // Data-phase state; async reset parks it on the always-ready default slave.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dsel_q <= DSEL_DEF;
      addr_q <= '0;
      act_q  <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      addr_q <= addr_d;
      act_q  <= act_d;
    end
  end

  // First-error capture; a fresh error arriving with a clear takes priority
  // so the newest fault is not lost.
  assign capture = msRdy & msErr & act_q & (~errVld_q | bus.ERR_CLR);

  always_comb begin
    errVld_d  = errVld_q;
    errAddr_d = errAddr_q;
    if (capture) begin
      errVld_d  = 1'b1;
      errAddr_d = addr_q;
    end else if (bus.ERR_CLR) begin
      errVld_d  = 1'b0;
      errAddr_d = '0;
    end
  end

  // Sticky error status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      errVld_q  <= 1'b0;
      errAddr_q <= '0;
    end else begin
      errVld_q  <= errVld_d;
      errAddr_q <= errAddr_d;
    end
  end

  assign bus.ERR_VLD  = errVld_q;
  assign bus.ERR_ADDR = errAddr_q;

endmodule

// File: tb/tb_cbl_slv_dec_mux.sv
// Self-checking bench for cbl_slv_dec_mux: directed scenarios plus a
// randomized run against a behavioural model of decode, data-phase
// ownership and first-error capture.
module tb_cbl_slv_dec_mux;
  import cbl_pkg::*;

  localparam int NS = 2;
  localparam logic [NS*32-1:0] BASES = {32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hF000_0000};

  logic CLK = 1'b0;
  logic nRST;
  logic nRSTOvl;

  int checks = 0;
  int errors = 0;

  // Model state: owning slave (NS = default), captured address, transfer flag.
  int          mSlave;
  logic [31:0] mAddr;
  logic        mAct;
  logic        mVld;
  logic [31:0] mErrAddr;

  cbl_slv_dec_mux_if #(.NSLV(NS)) bus ();
  cbl_slv_dec_mux_if #(.NSLV(NS)) ovl ();

  cbl_slv_dec_mux #(.NSLV(NS), .BASE_VEC(BASES), .MASK_VEC(MASKS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  cbl_slv_dec_mux #(.NSLV(NS), .BASE_VEC(64'h0), .MASK_VEC(64'h0)) u_ovl (
    .CLK  (CLK),
    .nRST (nRSTOvl),
    .bus  (ovl)
  );

  always #5 CLK = ~CLK;

  function automatic int refDecode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASKS[i*32 +: 32]) == BASES[i*32 +: 32]) return i;
    end
    return NS;
  endfunction

  function automatic logic [NS-1:0] refSel(input logic [31:0] a);
    int k;
    logic [NS-1:0] s;
    k = refDecode(a);
    s = '0;
    if (k < NS) s[k] = 1'b1;
    return s;
  endfunction

  function automatic logic modelRdy();
    return (mSlave == NS) ? bus.DRDY : bus.SxRDY_VEC[mSlave];
  endfunction

  function automatic logic modelErr();
    return (mSlave == NS) ? bus.DERR : bus.SxERR_VEC[mSlave];
  endfunction

  function automatic logic [38:0] modelRdt();
    return (mSlave == NS) ? bus.DRDT : bus.SxRDT_VEC[mSlave*39 +: 39];
  endfunction

  // Advance one clock and move the model by the pre-edge inputs.
  task automatic tick();
    logic r, e, cap, tr;
    int nxt;
    logic [31:0] a;
    r   = modelRdy();
    e   = modelErr();
    cap = r && e && mAct && (!mVld || bus.ERR_CLR);
    nxt = refDecode(bus.MmADDR);
    a   = bus.MmADDR;
    tr  = (bus.MmMOD == 3'b010) || (bus.MmMOD == 3'b011);
    @(posedge CLK);
    if (cap) begin
      mVld = 1'b1;
      mErrAddr = mAddr;
    end else if (bus.ERR_CLR) begin
      mVld = 1'b0;
      mErrAddr = '0;
    end
    if (r) begin
      mSlave = nxt;
      mAddr  = a;
      mAct   = tr;
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.MmADDR = 32'h8000_0000;
    bus.MmMOD = MOD_IDLE;
    bus.SxRDT_VEC = '0;
    bus.SxRDY_VEC = '1;
    bus.SxERR_VEC = '0;
    bus.DRDT = '0;
    bus.DRDY = 1'b1;
    bus.DERR = 1'b0;
    bus.ERR_CLR = 1'b0;
    mSlave = NS; mAddr = '0; mAct = 1'b0; mVld = 1'b0; mErrAddr = '0;
    repeat (2) @(posedge CLK);
    #2;
    checks++; if (bus.DxSEL !== 1'b1) begin errors++; $display("[TB] FAIL reset_dxsel: got %b expected 1", bus.DxSEL); end
    checks++; if (bus.SxSEL !== 2'b00) begin errors++; $display("[TB] FAIL reset_sxsel: got %b expected 00", bus.SxSEL); end
    checks++; if (bus.MsRDY !== 1'b1) begin errors++; $display("[TB] FAIL reset_msrdy: got %b expected 1", bus.MsRDY); end
    checks++; if (bus.MsRDT !== 39'h0) begin errors++; $display("[TB] FAIL reset_msrdt: got %h expected 0", bus.MsRDT); end
    checks++; if (bus.MsERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_mserr: got %b expected 0", bus.MsERR); end
    checks++; if (bus.ERR_VLD !== 1'b0) begin errors++; $display("[TB] FAIL reset_errvld: got %b expected 0", bus.ERR_VLD); end
    checks++; if (bus.ERR_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_erraddr: got %h expected 0", bus.ERR_ADDR); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_read();
    bus.MmMOD = MOD_LDADDR;
    bus.MmADDR = 32'h0000_1000;
    #1;
    checks++; if (bus.SxSEL !== 2'b01) begin errors++; $display("[TB] FAIL read_sxsel: got %b expected 01", bus.SxSEL); end
    checks++; if (bus.DxSEL !== 1'b0) begin errors++; $display("[TB] FAIL read_dxsel: got %b expected 0", bus.DxSEL); end
    tick();
    bus.SxRDT_VEC[0 +: 39] = 39'h12345678;
    bus.SxRDY_VEC[0] = 1'b1;
    bus.MmMOD = MOD_IDLE;
    bus.MmADDR = 32'h8000_0000;
    #1;
    checks++; if (bus.MsRDT !== 39'h12345678) begin errors++; $display("[TB] FAIL read_msrdt: got %h expected 12345678", bus.MsRDT); end
    checks++; if (bus.MsRDY !== 1'b1) begin errors++; $display("[TB] FAIL read_msrdy: got %b expected 1", bus.MsRDY); end
    tick();
  endtask

  task automatic test_back_to_back_wait();
    bus.MmMOD = MOD_LDADDR;
    bus.MmADDR = 32'h4000_0004;
    tick();
    bus.SxRDY_VEC[1] = 1'b0;
    bus.SxRDT_VEC[39 +: 39] = 39'h11_1111;
    bus.SxRDT_VEC[0 +: 39] = 39'h22_2222;
    bus.MmADDR = 32'h0000_0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.MsRDY !== 1'b0) begin errors++; $display("[TB] FAIL wait_msrdy_low%0d: got %b expected 0", c, bus.MsRDY); end
      tick();
    end
    bus.SxRDY_VEC[1] = 1'b1;
    #1;
    checks++; if (bus.MsRDY !== 1'b1) begin errors++; $display("[TB] FAIL wait_msrdy_high: got %b expected 1", bus.MsRDY); end
    checks++; if (bus.MsRDT !== 39'h11_1111) begin errors++; $display("[TB] FAIL wait_held_slave1: got %h expected 111111", bus.MsRDT); end
    tick();
    bus.MmMOD = MOD_IDLE;
    bus.MmADDR = 32'h8000_0000;
    #1;
    checks++; if (bus.MsRDT !== 39'h22_2222) begin errors++; $display("[TB] FAIL wait_switch_slave0: got %h expected 222222", bus.MsRDT); end
    tick();
  endtask

  task automatic test_error_capture();
    bus.MmMOD = MOD_LDADDR;
    bus.MmADDR = 32'h8000_0010;
    #1;
    checks++; if (bus.DxSEL !== 1'b1) begin errors++; $display("[TB] FAIL err_dxsel: got %b expected 1", bus.DxSEL); end
    tick();
    bus.DERR = 1'b1;
    bus.MmADDR = 32'h9000_0000;
    #1;
    checks++; if (bus.MsERR !== 1'b1) begin errors++; $display("[TB] FAIL err_mserr: got %b expected 1", bus.MsERR); end
    tick();
    checks++; if (bus.ERR_VLD !== 1'b1) begin errors++; $display("[TB] FAIL err_vld: got %b expected 1", bus.ERR_VLD); end
    checks++; if (bus.ERR_ADDR !== 32'h8000_0010) begin errors++; $display("[TB] FAIL err_addr: got %h expected 80000010", bus.ERR_ADDR); end
    bus.MmMOD = MOD_IDLE;
    bus.MmADDR = 32'h8000_0000;
    tick();
    checks++; if (bus.ERR_ADDR !== 32'h8000_0010) begin errors++; $display("[TB] FAIL err_sticky: got %h expected 80000010", bus.ERR_ADDR); end
    bus.DERR = 1'b0;
  endtask

  task automatic test_clear_collision();
    bus.MmMOD = MOD_LDADDR;
    bus.MmADDR = 32'hA000_0000;
    tick();
    bus.DERR = 1'b1;
    bus.ERR_CLR = 1'b1;
    bus.MmMOD = MOD_IDLE;
    bus.MmADDR = 32'h8000_0000;
    tick();
    checks++; if (bus.ERR_VLD !== 1'b1) begin errors++; $display("[TB] FAIL clr_win_vld: got %b expected 1", bus.ERR_VLD); end
    checks++; if (bus.ERR_ADDR !== 32'hA000_0000) begin errors++; $display("[TB] FAIL clr_win_addr: got %h expected a0000000", bus.ERR_ADDR); end
    bus.DERR = 1'b0;
    tick();
    checks++; if (bus.ERR_VLD !== 1'b0) begin errors++; $display("[TB] FAIL clr_vld: got %b expected 0", bus.ERR_VLD); end
    checks++; if (bus.ERR_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL clr_addr: got %h expected 0", bus.ERR_ADDR); end
    bus.ERR_CLR = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] w;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[31:28] = 4'h0;
        1: a[31:28] = 4'h4;
        default: ;
      endcase
      bus.MmADDR = a;
      bus.MmMOD = 3'($urandom_range(0, 7));
      for (int i = 0; i < NS; i++) begin
        w = {$urandom, $urandom};
        bus.SxRDT_VEC[i*39 +: 39] = w[38:0];
        bus.SxRDY_VEC[i] = ($urandom_range(0, 3) != 0);
        bus.SxERR_VEC[i] = ($urandom_range(0, 3) == 0);
      end
      w = {$urandom, $urandom};
      bus.DRDT = w[38:0];
      bus.DRDY = ($urandom_range(0, 3) != 0);
      bus.DERR = ($urandom_range(0, 3) == 0);
      bus.ERR_CLR = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (bus.SxSEL !== refSel(a)) begin errors++; $display("[TB] FAIL rnd_sxsel@%0d: got %b expected %b", n, bus.SxSEL, refSel(a)); end
      checks++; if (bus.DxSEL !== (refDecode(a) == NS)) begin errors++; $display("[TB] FAIL rnd_dxsel@%0d: got %b expected %b", n, bus.DxSEL, refDecode(a) == NS); end
      checks++; if (bus.MsRDY !== modelRdy()) begin errors++; $display("[TB] FAIL rnd_msrdy@%0d: got %b expected %b", n, bus.MsRDY, modelRdy()); end
      checks++; if (bus.MsRDT !== modelRdt()) begin errors++; $display("[TB] FAIL rnd_msrdt@%0d: got %h expected %h", n, bus.MsRDT, modelRdt()); end
      checks++; if (bus.MsERR !== modelErr()) begin errors++; $display("[TB] FAIL rnd_mserr@%0d: got %b expected %b", n, bus.MsERR, modelErr()); end
      checks++; if (bus.ERR_VLD !== mVld) begin errors++; $display("[TB] FAIL rnd_errvld@%0d: got %b expected %b", n, bus.ERR_VLD, mVld); end
      checks++; if (bus.ERR_ADDR !== mErrAddr) begin errors++; $display("[TB] FAIL rnd_erraddr@%0d: got %h expected %h", n, bus.ERR_ADDR, mErrAddr); end
      tick();
    end
    bus.ERR_CLR = 1'b0;
  endtask

  task automatic test_overlap_reset();
    @(negedge CLK);
    nRSTOvl = 1'b1;
    ovl.MmMOD = MOD_BUSY;
    ovl.MmADDR = $urandom;
    ovl.SxRDY_VEC = 2'b11;
    ovl.SxERR_VEC = 2'b11;
    ovl.DRDY = 1'b1;
    ovl.DERR = 1'b0;
    #1;
    checks++; if (ovl.SxSEL !== 2'b01) begin errors++; $display("[TB] FAIL ovl_sxsel: got %b expected 01", ovl.SxSEL); end
    checks++; if (ovl.DxSEL !== 1'b0) begin errors++; $display("[TB] FAIL ovl_dxsel: got %b expected 0", ovl.DxSEL); end
    @(posedge CLK); #1;
    checks++; if (ovl.MsERR !== 1'b1) begin errors++; $display("[TB] FAIL ovl_mserr: got %b expected 1", ovl.MsERR); end
    @(posedge CLK); #1;
    checks++; if (ovl.ERR_VLD !== 1'b0) begin errors++; $display("[TB] FAIL ovl_no_capture: got %b expected 0", ovl.ERR_VLD); end
    ovl.SxRDY_VEC = 2'b00;
    #1;
    checks++; if (ovl.MsRDY !== 1'b0) begin errors++; $display("[TB] FAIL ovl_wait: got %b expected 0", ovl.MsRDY); end
    #2;
    nRSTOvl = 1'b0;
    #1;
    checks++; if (ovl.MsRDY !== 1'b1) begin errors++; $display("[TB] FAIL ovl_async_rst_rdy: got %b expected 1", ovl.MsRDY); end
    checks++; if (ovl.ERR_VLD !== 1'b0) begin errors++; $display("[TB] FAIL ovl_rst_errvld: got %b expected 0", ovl.ERR_VLD); end
    @(negedge CLK);
    nRSTOvl = 1'b1;
  endtask

  initial begin
    nRSTOvl = 1'b0;
    ovl.MmADDR = '0;
    ovl.MmMOD = MOD_IDLE;
    ovl.SxRDT_VEC = '0;
    ovl.SxRDY_VEC = '1;
    ovl.SxERR_VEC = '0;
    ovl.DRDT = '0;
    ovl.DRDY = 1'b1;
    ovl.DERR = 1'b0;
    ovl.ERR_CLR = 1'b0;
    test_reset();
    test_read();
    test_back_to_back_wait();
    test_error_capture();
    test_clear_collision();
    test_random();
    test_overlap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
